// File: rtl/filters_pkg.sv
// filters_pkg: field widths, enums and the default coefficient table shared by the coefficient bank.
package filters_pkg;
  localparam int RATE_WIDTH   = 32;
  localparam int CX_WIDTH     = 40;
  localparam int CXN_WIDTH    = 8;
  localparam int CY_WIDTH     = 24;
  localparam int NUM_FIELDS   = 8;
  localparam int NUM_DEFAULTS = 8;
  typedef enum logic [2:0] {F_RATE, F_CX, F_CX0, F_CX1, F_CX2, F_CY0, F_CY1, F_CY2} field_e;
  typedef enum logic [1:0] {S_IDLE, S_MUTE, S_LOAD, S_APPLY} state_e;
  // rate, cx, cx0, cx1, cx2, cy0, cy1, cy2
  localparam logic [39:0] DEFAULT_COEFS [NUM_DEFAULTS][NUM_FIELDS] = '{
    '{40'd7056000, 40'd4258969, 40'd3, 40'd3, 40'd1, 40'hA123C9, 40'h3C5E1A, 40'hF0A3B2},
    '{40'd3528000, 40'd3170561, 40'd2, 40'd2, 40'd1, 40'hB2E411, 40'h2A4C07, 40'hF61D3E},
    '{40'd1764000, 40'd2420697, 40'd1, 40'd1, 40'd0, 40'hC410F5, 40'h1B2230, 40'h000000},
    '{40'd882000,  40'd1812540, 40'd1, 40'd2, 40'd1, 40'hD02A77, 40'h12F4A1, 40'hFA0C11},
    '{40'd6144000, 40'd5133312, 40'd4, 40'd3, 40'd2, 40'h98B2C4, 40'h41A7E3, 40'hEE1290},
    '{40'd3072000, 40'd3866121, 40'd3, 40'd2, 40'd1, 40'hA9F03D, 40'h33B0C2, 40'hF3322A},
    '{40'd1536000, 40'd2907344, 40'd2, 40'd1, 40'd1, 40'hBB7713, 40'h26610F, 40'hF81DE4},
    '{40'd768000,  40'd2011075, 40'd1, 40'd1, 40'd1, 40'hCA01E5, 40'h1C3B22, 40'hFC0A55}
  };
  function automatic logic [39:0] default_field(int idx, field_e f);
    int r;
    r = (idx < NUM_DEFAULTS) ? idx : 0;
    return DEFAULT_COEFS[r[2:0]][f];
  endfunction
endpackage

// File: rtl/filters_coef_ram.sv
// filters_coef_ram: one coefficient field for every table entry; write-first registered read.
module filters_coef_ram
  import filters_pkg::*;
#(
  parameter int     DEPTH = 16,
  parameter int     WIDTH = 32,
  parameter field_e FIELD = F_RATE,
  localparam int    AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  typedef logic [WIDTH-1:0] mem_t [DEPTH];
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = WIDTH'(default_field(i, FIELD));
    return m;
  endfunction
  mem_t mem = init_mem();
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= (we && wa == ra) ? wd : mem[ra];
  end
endmodule

// File: rtl/filters_coef_bank.sv
// filters_coef_bank: coefficient table with a mute/load/apply sequence that swaps all outputs atomically.
module filters_coef_bank
  import filters_pkg::*;
#(
  parameter int  NUM_FILTERS = 16,
  parameter int  MUTE_CYCLES = 4,
  parameter int  RATE_W      = RATE_WIDTH,
  parameter int  CX_W        = CX_WIDTH,
  parameter int  CXN_W       = CXN_WIDTH,
  parameter int  CY_W        = CY_WIDTH,
  localparam int IW          = $clog2(NUM_FILTERS),
  localparam int CW          = $clog2(MUTE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     afilter_sw,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [2:0]        wr_field,
  input  logic [39:0]       wr_data,
  output logic [RATE_W-1:0] aflt_rate,
  output logic [CX_W-1:0]   acx,
  output logic [CXN_W-1:0]  acx0,
  output logic [CXN_W-1:0]  acx1,
  output logic [CXN_W-1:0]  acx2,
  output logic [CY_W-1:0]   acy0,
  output logic [CY_W-1:0]   acy1,
  output logic [CY_W-1:0]   acy2,
  output logic              flt_mute,
  output logic              coef_changed,
  output logic              busy
);
  localparam logic [IW:0] NF = (IW+1)'(NUM_FILTERS);
  state_e            state, state_n;
  logic [IW-1:0]     target, active_idx, sw_c;
  logic [CW-1:0]     cnt;
  logic              pending, wr_ok, start, load, apply, pend_set;
  logic [7:0]        we;
  logic [RATE_W-1:0] q_rate;
  logic [CX_W-1:0]   q_cx;
  logic [CXN_W-1:0]  q_cx0, q_cx1, q_cx2;
  logic [CY_W-1:0]   q_cy0, q_cy1, q_cy2;
  always_comb begin
    sw_c     = ({1'b0, afilter_sw} < NF) ? afilter_sw : '0;
    wr_ok    = wr_en && ({1'b0, wr_idx} < NF);
    we       = wr_ok ? 8'(1) << wr_field : '0;
    start    = state == S_IDLE && (sw_c != active_idx || pending);
    load     = state == S_LOAD;
    apply    = state == S_APPLY;
    pend_set = wr_ok && (wr_idx == active_idx || (busy && wr_idx == target));
    state_n  = start ? S_MUTE
             : (state == S_MUTE && cnt == CW'(MUTE_CYCLES - 1)) ? S_LOAD
             : load ? S_APPLY
             : apply ? S_IDLE
             : state;
  end
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      active_idx   <= '0;
      target       <= '0;
      pending      <= 1'b0;
      cnt          <= '0;
      flt_mute     <= 1'b0;
      busy         <= 1'b0;
      coef_changed <= 1'b0;
      aflt_rate    <= RATE_W'(default_field(0, F_RATE));
      acx          <= CX_W'(default_field(0, F_CX));
      acx0         <= CXN_W'(default_field(0, F_CX0));
      acx1         <= CXN_W'(default_field(0, F_CX1));
      acx2         <= CXN_W'(default_field(0, F_CX2));
      acy0         <= CY_W'(default_field(0, F_CY0));
      acy1         <= CY_W'(default_field(0, F_CY1));
      acy2         <= CY_W'(default_field(0, F_CY2));
    end else begin
      coef_changed <= apply;
      cnt          <= (state == S_MUTE) ? cnt + 1'b1 : '0;
      pending      <= pend_set || (pending && !start);
      if (start) begin
        target   <= sw_c;
        flt_mute <= 1'b1;
        busy     <= 1'b1;
      end
      if (apply) begin
        active_idx <= target;
        flt_mute   <= 1'b0;
        busy       <= 1'b0;
        aflt_rate  <= q_rate;
        acx        <= q_cx;
        acx0       <= q_cx0;
        acx1       <= q_cx1;
        acx2       <= q_cx2;
        acy0       <= q_cy0;
        acy1       <= q_cy1;
        acy2       <= q_cy2;
      end
    end
  end
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(RATE_W), .FIELD(F_RATE)) u_rate (.clk, .we(we[0]), .wa(wr_idx), .wd(wr_data[RATE_W-1:0]), .re(load), .ra(target), .rd(q_rate));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CX_W),   .FIELD(F_CX))   u_cx   (.clk, .we(we[1]), .wa(wr_idx), .wd(wr_data[CX_W-1:0]),   .re(load), .ra(target), .rd(q_cx));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CXN_W),  .FIELD(F_CX0))  u_cx0  (.clk, .we(we[2]), .wa(wr_idx), .wd(wr_data[CXN_W-1:0]),  .re(load), .ra(target), .rd(q_cx0));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CXN_W),  .FIELD(F_CX1))  u_cx1  (.clk, .we(we[3]), .wa(wr_idx), .wd(wr_data[CXN_W-1:0]),  .re(load), .ra(target), .rd(q_cx1));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CXN_W),  .FIELD(F_CX2))  u_cx2  (.clk, .we(we[4]), .wa(wr_idx), .wd(wr_data[CXN_W-1:0]),  .re(load), .ra(target), .rd(q_cx2));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CY_W),   .FIELD(F_CY0))  u_cy0  (.clk, .we(we[5]), .wa(wr_idx), .wd(wr_data[CY_W-1:0]),   .re(load), .ra(target), .rd(q_cy0));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CY_W),   .FIELD(F_CY1))  u_cy1  (.clk, .we(we[6]), .wa(wr_idx), .wd(wr_data[CY_W-1:0]),   .re(load), .ra(target), .rd(q_cy1));
  filters_coef_ram #(.DEPTH(NUM_FILTERS), .WIDTH(CY_W),   .FIELD(F_CY2))  u_cy2  (.clk, .we(we[7]), .wa(wr_idx), .wd(wr_data[CY_W-1:0]),   .re(load), .ra(target), .rd(q_cy2));
endmodule

// File: tb/tb_filters_coef_bank.sv
// tb_filters_coef_bank: directed pins plus randomized traffic checked every cycle against a timeline model.
module tb_filters_coef_bank;
  localparam int NF = 12;
  localparam int MC = 4;
  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
  logic [3:0]  afilter_sw = '0, wr_idx = '0;
  logic [2:0]  wr_field = '0;
  logic [39:0] wr_data = '0;
  logic [31:0] aflt_rate;
  logic [39:0] acx;
  logic [7:0]  acx0, acx1, acx2;
  logic [23:0] acy0, acy1, acy2;
  logic        flt_mute, coef_changed, busy;
  int n_chk = 0, n_fail = 0;
  filters_coef_bank #(.NUM_FILTERS(NF), .MUTE_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .afilter_sw(afilter_sw), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_field(wr_field), .wr_data(wr_data), .aflt_rate(aflt_rate), .acx(acx), .acx0(acx0),
    .acx1(acx1), .acx2(acx2), .acy0(acy0), .acy1(acy1), .acy2(acy2), .flt_mute(flt_mute),
    .coef_changed(coef_changed), .busy(busy));
  always #5 clk = ~clk;
  logic [39:0] dflt [8][8] = '{
    '{40'd7056000, 40'd4258969, 40'd3, 40'd3, 40'd1, 40'hA123C9, 40'h3C5E1A, 40'hF0A3B2},
    '{40'd3528000, 40'd3170561, 40'd2, 40'd2, 40'd1, 40'hB2E411, 40'h2A4C07, 40'hF61D3E},
    '{40'd1764000, 40'd2420697, 40'd1, 40'd1, 40'd0, 40'hC410F5, 40'h1B2230, 40'h000000},
    '{40'd882000,  40'd1812540, 40'd1, 40'd2, 40'd1, 40'hD02A77, 40'h12F4A1, 40'hFA0C11},
    '{40'd6144000, 40'd5133312, 40'd4, 40'd3, 40'd2, 40'h98B2C4, 40'h41A7E3, 40'hEE1290},
    '{40'd3072000, 40'd3866121, 40'd3, 40'd2, 40'd1, 40'hA9F03D, 40'h33B0C2, 40'hF3322A},
    '{40'd1536000, 40'd2907344, 40'd2, 40'd1, 40'd1, 40'hBB7713, 40'h26610F, 40'hF81DE4},
    '{40'd768000,  40'd2011075, 40'd1, 40'd1, 40'd1, 40'hCA01E5, 40'h1C3B22, 40'hFC0A55}};
  int wid [8] = '{32, 40, 8, 8, 8, 24, 24, 24};
  logic [39:0] tbl [NF][8];
  logic [39:0] m_out [8], snap [8];
  int  m_act, m_tgt, m_t;
  bit  m_busy, m_pend, m_chg, m_started;
  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Model: table as plain arrays, a swap is a countdown from request to apply.
  initial begin
    bit set, start, wok;
    int sw;
    for (int i = 0; i < NF; i++) for (int f = 0; f < 8; f++) tbl[i][f] = dflt[i < 8 ? i : 0][f];
    forever begin
      @(posedge clk);
      wok = wr_en && int'(wr_idx) < NF;
      set = wok && (int'(wr_idx) == m_act || (m_busy && int'(wr_idx) == m_tgt));
      if (wok) tbl[wr_idx][wr_field] = wr_data & ((40'd1 << wid[wr_field]) - 40'd1);
      sw = int'(afilter_sw) < NF ? int'(afilter_sw) : 0;
      if (reset) begin
        m_busy = 0; m_pend = 0; m_act = 0; m_chg = 0;
        for (int f = 0; f < 8; f++) m_out[f] = dflt[0][f];
      end else begin
        m_chg = 0; start = 0;
        if (m_busy) begin
          m_t++;
          if (m_t == MC + 1) for (int f = 0; f < 8; f++) snap[f] = tbl[m_tgt][f];
          if (m_t == MC + 2) begin
            m_out = snap; m_act = m_tgt; m_busy = 0; m_chg = 1;
          end
        end else if (sw != m_act || m_pend) begin
          m_busy = 1; m_t = 0; m_tgt = sw; start = 1;
        end
        m_pend = set || (m_pend && !start);
      end
      m_started = 1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("aflt_rate", 40'(aflt_rate), m_out[0]);
      chk("acx", acx, m_out[1]);
      chk("acx0", 40'(acx0), m_out[2]);
      chk("acx1", 40'(acx1), m_out[3]);
      chk("acx2", 40'(acx2), m_out[4]);
      chk("acy0", 40'(acy0), m_out[5]);
      chk("acy1", 40'(acy1), m_out[6]);
      chk("acy2", 40'(acy2), m_out[7]);
      chk("flt_mute", 40'(flt_mute), 40'(m_busy));
      chk("busy", 40'(busy), 40'(m_busy));
      chk("coef_changed", 40'(coef_changed), 40'(m_chg));
    end
  end
  initial begin
    int cnt, first_cx;
    tick(2);
    reset = 1'b0;
    chk("rst_rate", 40'(aflt_rate), 40'd7056000);
    chk("rst_acx", acx, 40'd4258969);
    chk("rst_acx0", 40'(acx0), 40'd3);
    chk("rst_acx1", 40'(acx1), 40'd3);
    chk("rst_acx2", 40'(acx2), 40'd1);
    chk("rst_acy0", 40'(acy0), 40'hA123C9);
    chk("rst_mute", 40'(flt_mute), 40'd0);
    afilter_sw = 4'd13;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(1); cnt += int'(busy); end
    chk("oob_no_seq", 40'(cnt), 40'd0);
    chk("oob_acx", acx, 40'd4258969);
    afilter_sw = 4'd2;
    tick(1);
    chk("sw2_mute_n", 40'(flt_mute), 40'd1);
    tick(5);
    chk("sw2_mute_n5", 40'(flt_mute), 40'd1);
    chk("sw2_nochg_n5", 40'(coef_changed), 40'd0);
    tick(1);
    chk("sw2_acx", acx, 40'd2420697);
    chk("sw2_acx2", 40'(acx2), 40'd0);
    chk("sw2_acy2", 40'(acy2), 40'd0);
    chk("sw2_chg", 40'(coef_changed), 40'd1);
    chk("sw2_unmute", 40'(flt_mute), 40'd0);
    tick(1);
    chk("sw2_chg_pulse", 40'(coef_changed), 40'd0);
    afilter_sw = 4'd1;
    tick(10);
    wr_en = 1'b1; wr_idx = 4'd1; wr_field = 3'd1; wr_data = 40'd12345;
    tick(1);
    wr_en = 1'b0;
    tick(7);
    chk("wr_active_acx", acx, 40'd12345);
    chk("wr_active_chg", 40'(coef_changed), 40'd1);
    tick(2);
    wr_en = 1'b1; wr_idx = 4'd3; wr_field = 3'd1; wr_data = 40'd777;
    tick(1);
    wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(1); cnt += int'(busy); end
    chk("wr_other_no_seq", 40'(cnt), 40'd0);
    afilter_sw = 4'd4;
    tick(2);
    afilter_sw = 4'd6;
    cnt = 0; first_cx = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (coef_changed) begin
        cnt++;
        if (cnt == 1) first_cx = int'(acx);
      end
    end
    chk("toggle_pulses", 40'(cnt), 40'd2);
    chk("toggle_first", 40'(first_cx), 40'd5133312);
    chk("toggle_final", acx, 40'd2907344);
    wr_en = 1'b1; wr_idx = 4'd5; wr_field = 3'd0; wr_data = 40'd999;
    tick(1);
    wr_en = 1'b0;
    afilter_sw = 4'd5;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("rst_load_acx", acx, 40'd4258969);
    chk("rst_load_chg", 40'(coef_changed), 40'd0);
    chk("rst_load_busy", 40'(busy), 40'd0);
    reset = 1'b0;
    tick(10);
    chk("rst_keeps_table", 40'(aflt_rate), 40'd999);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) afilter_sw = 4'($urandom);
      wr_en    = $urandom_range(3) == 0;
      wr_idx   = $urandom_range(2) == 0 ? afilter_sw : 4'($urandom);
      wr_field = 3'($urandom);
      wr_data  = {8'($urandom), 32'($urandom)};
      reset    = $urandom_range(299) == 0;
      tick(1);
    end
    reset = 1'b0; wr_en = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
